button_debouncer: RTL and testbench

- Conditions raw board push-button / switch inputs before they reach the MCU top.
- Typical use: board reset button feeding rvsteel_mcu reset, and button bits feeding gpio_input.
- Per input bit:
  - 2-flop synchronizer,
  - stability counter that only accepts a new level after it has been held for a programmable time,
  - one-cycle rise/fall strobes.
- Replaces the single-flop reset registration in board tops.

---
 rtl/button_debouncer_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 81 ++++++++
 rtl/button_debouncer.sv | 38 +++
 tb/tb_button_debouncer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared constants and helpers for the push-button debouncer.
// Debounce length is derived from clock rate and required stable time, clamped to one cycle.
package button_debouncer_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  function automatic int debounce_cycles(input int clock_frequency, input int time_us);
    int cycles;
    cycles = (clock_frequency / 1000000) * time_us;
    return (cycles < 1) ? 1 : cycles;
  endfunction

  function automatic int counter_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer, stability counter, level and edge strobes.
// Level follows a clean input after CYCLES+2 edges; no flow control, strobes are one cycle wide.
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int CYCLES = 1,
  parameter bit IDLE   = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW   = counter_width(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  state_t        w_state;
  logic          w_level_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_s1    <= IDLE;
      r_s2    <= IDLE;
      r_level <= IDLE;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_raw;
      r_s2    <= r_s1;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Any return of s2 to the accepted level lands in STABLE, which discards partial progress.
  always_comb begin
    w_state     = (r_s2 != r_level) ? PENDING : STABLE;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_cnt_nxt   = '0;
    case (w_state)
      STABLE: begin
        w_cnt_nxt = '0;
      end
      PENDING: begin
        if (r_cnt == LAST) begin
          w_level_nxt = r_s2;
          w_rise_nxt  = r_s2;
          w_fall_nxt  = ~r_s2;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_INPUTS independent raw button pads into clock-synchronous levels and edge strobes.
// Latency DEBOUNCE_CYCLES+2 edges per channel; no backpressure, strobes are single-cycle pulses.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY  = 12000000,
  parameter int DEBOUNCE_TIME_US = 10000,
  parameter int NUM_INPUTS       = 1,
  parameter int IDLE_LEVEL       = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] button_raw,
  output logic [NUM_INPUTS-1:0] button_level,
  output logic [NUM_INPUTS-1:0] button_rise,
  output logic [NUM_INPUTS-1:0] button_fall
);

  localparam int CYCLES = debounce_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);
  localparam bit IDLE   = (IDLE_LEVEL != 0);

  generate
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
      debounce_channel #(
        .CYCLES(CYCLES),
        .IDLE  (IDLE)
      ) u_ch (
        .i_clock(clock),
        .i_reset(reset),
        .i_raw  (button_raw[g]),
        .o_level(button_level[g]),
        .o_rise (button_rise[g]),
        .o_fall (button_fall[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: 8-cycle debounce on two channels plus a clamped (1-cycle) single-channel instance.
module tb_button_debouncer;

  logic       clock;
  logic       reset;
  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       raw_c;
  logic       level_c;
  logic       rise_c;
  logic       fall_c;

  int errors = 0;
  int checks = 0;

  button_debouncer #(
    .CLOCK_FREQUENCY (1000000),
    .DEBOUNCE_TIME_US(8),
    .NUM_INPUTS      (2),
    .IDLE_LEVEL      (0)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .button_raw  (raw),
    .button_level(level),
    .button_rise (rise),
    .button_fall (fall)
  );

  button_debouncer #(
    .CLOCK_FREQUENCY (1000000),
    .DEBOUNCE_TIME_US(0),
    .NUM_INPUTS      (1),
    .IDLE_LEVEL      (0)
  ) u_clamp (
    .clock       (clock),
    .reset       (reset),
    .button_raw  (raw_c),
    .button_level(level_c),
    .button_rise (rise_c),
    .button_fall (fall_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw   = 2'b00;
    raw_c = 1'b0;
    settle(3);
    checks++;
    if (level !== 2'b00 || rise !== 2'b00 || fall !== 2'b00 || level_c !== 1'b0 || rise_c !== 1'b0 || fall_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: level=%b rise=%b fall=%b clamp=%b%b%b, want all 0", level, rise, fall, level_c, rise_c, fall_c);
    end
    reset = 1'b0;
    settle(3);
    checks++;
    if (level !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: level=%b rise=%b fall=%b, want 00 00 00", level, rise, fall);
    end
  endtask

  task automatic test_rise();
    logic [1:0] el, er;
    raw[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      el = (i >= 10) ? 2'b01 : 2'b00;
      er = (i == 10) ? 2'b01 : 2'b00;
      checks++;
      if (level !== el || rise !== er || fall !== 2'b00) begin
        errors++;
        $display("FAIL rise edge %0d: level=%b rise=%b fall=%b, want %b %b 00", i, level, rise, fall, el, er);
      end
    end
  endtask

  task automatic test_fall();
    logic [1:0] el, ef;
    raw[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      el = (i < 10) ? 2'b01 : 2'b00;
      ef = (i == 10) ? 2'b01 : 2'b00;
      checks++;
      if (level !== el || fall !== ef || rise !== 2'b00) begin
        errors++;
        $display("FAIL fall edge %0d: level=%b rise=%b fall=%b, want %b 00 %b", i, level, rise, fall, el, ef);
      end
    end
  endtask

  task automatic test_bounce();
    logic [13:0] seq;
    logic [1:0]  el, er;
    seq = 14'b0000_11111_00_111;  // LSB first: high 3, low 2, high 5, low 4
    for (int i = 0; i < 14; i++) begin
      raw[0] = seq[i];
      tick();
      checks++;
      if (level !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
        errors++;
        $display("FAIL bounce step %0d: level=%b rise=%b fall=%b, want 00 00 00", i, level, rise, fall);
      end
    end
    raw[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      el = (i >= 10) ? 2'b01 : 2'b00;
      er = (i == 10) ? 2'b01 : 2'b00;
      checks++;
      if (level !== el || rise !== er || fall !== 2'b00) begin
        errors++;
        $display("FAIL bounce_hold edge %0d: level=%b rise=%b fall=%b, want %b %b 00", i, level, rise, fall, el, er);
      end
    end
    raw[0] = 1'b0;
    settle(12);
    checks++;
    if (level !== 2'b00) begin
      errors++;
      $display("FAIL bounce_restore: level=%b, want 00", level);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] el, er;
    raw = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      tick();
      el = (i >= 10) ? 2'b11 : 2'b00;
      er = (i == 10) ? 2'b11 : 2'b00;
      checks++;
      if (level !== el || rise !== er || fall !== 2'b00) begin
        errors++;
        $display("FAIL simultaneous edge %0d: level=%b rise=%b fall=%b, want %b %b 00", i, level, rise, fall, el, er);
      end
    end
    raw = 2'b00;
    settle(12);
    checks++;
    if (level !== 2'b00) begin
      errors++;
      $display("FAIL simultaneous_restore: level=%b, want 00", level);
    end
  endtask

  task automatic test_stagger();
    logic [1:0] el, er;
    raw[0] = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 3) raw[1] = 1'b1;
      el = {(i >= 13), (i >= 10)};
      er = {(i == 13), (i == 10)};
      checks++;
      if (level !== el || rise !== er || fall !== 2'b00) begin
        errors++;
        $display("FAIL stagger edge %0d: level=%b rise=%b fall=%b, want %b %b 00", i, level, rise, fall, el, er);
      end
    end
    raw = 2'b00;
    settle(12);
  endtask

  task automatic test_reset_mid();
    logic [1:0] el, er;
    raw[0] = 1'b1;
    settle(5);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (level !== 2'b00 || rise !== 2'b00 || fall !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_async: level=%b rise=%b fall=%b, want 00 00 00", level, rise, fall);
    end
    settle(2);
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      el = (i >= 10) ? 2'b01 : 2'b00;
      er = (i == 10) ? 2'b01 : 2'b00;
      checks++;
      if (level !== el || rise !== er || fall !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid edge %0d: level=%b rise=%b fall=%b, want %b %b 00", i, level, rise, fall, el, er);
      end
    end
    raw[0] = 1'b0;
    settle(12);
  endtask

  task automatic test_clamp();
    logic el, er, ef;
    raw_c = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      el = (i >= 3);
      er = (i == 3);
      checks++;
      if (level_c !== el || rise_c !== er || fall_c !== 1'b0) begin
        errors++;
        $display("FAIL clamp_rise edge %0d: level=%b rise=%b fall=%b, want %b %b 0", i, level_c, rise_c, fall_c, el, er);
      end
    end
    raw_c = 1'b0;
    settle(4);
    // One-cycle pulse on the pad becomes a one-cycle pulse on the level.
    raw_c = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) raw_c = 1'b0;
      el = (i == 3);
      er = (i == 3);
      ef = (i == 4);
      checks++;
      if (level_c !== el || rise_c !== er || fall_c !== ef) begin
        errors++;
        $display("FAIL clamp_glitch edge %0d: level=%b rise=%b fall=%b, want %b %b %b", i, level_c, rise_c, fall_c, el, er, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_bounce();
    test_simultaneous();
    test_stagger();
    test_reset_mid();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
